car_sensor: RTL

Vehicle-detection front end for the highway/country-road signal controller. Conditions the raw country-road loop sensor through a synchroniser and debouncer, then counts waiting cars. Models departures while the country road shows green, using the controller's `cntry` output as feedback. Drives the controller's `x` request input high whenever at least one car is waiting.

---
 rtl/car_sensor.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/car_sensor.sv
// car_sensor: country-road vehicle detector front end.
// Synchronises and debounces the loop sensor, counts waiting cars, models
// departures during country green and raises x while any car is waiting.
module car_sensor #(
  parameter int DEB_CYCLES    = 4,
  parameter int DEPART_CYCLES = 3,
  parameter int MAX_CARS      = 15,
  parameter int CNT_W         = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             sensor_raw,
  input  logic [1:0]       cntry,
  output logic             x,
  output logic [CNT_W-1:0] car_count,
  output logic             sensor_clean,
  output logic             overflow
);

  // Debounce states:
  //   LOW_STABLE  | clean level 0, synchronised sensor agrees
  //   LOW_CHECK   | clean level 0, sensor has read 1 for a run of samples
  //   HIGH_STABLE | clean level 1, synchronised sensor agrees
  //   HIGH_CHECK  | clean level 1, sensor has read 0 for a run of samples
  typedef enum logic [1:0] {
    LOW_STABLE  = 2'd0,
    LOW_CHECK   = 2'd1,
    HIGH_STABLE = 2'd2,
    HIGH_CHECK  = 2'd3
  } deb_state_t;

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int TW = $clog2(DEPART_CYCLES + 1);
  localparam logic [1:0] GREEN = 2'd0;

  logic          s1, s2;
  deb_state_t    state, state_n;
  logic [DW-1:0] deb_cnt, deb_cnt_n;
  logic          deb_done;
  logic          clean_n;
  logic          arrival;
  logic [TW-1:0] tmr, tmr_n;
  logic          green_active;
  logic          departure;
  logic          at_max;

  // Two-flop synchroniser for the asynchronous loop detector.
  always_ff @(posedge clock) begin
    if (clear) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= sensor_raw;
      s2 <= s1;
    end
  end

  // Debounce state register, run counter and registered clean level.
  always_ff @(posedge clock) begin
    if (clear) begin
      state        <= LOW_STABLE;
      deb_cnt      <= '0;
      sensor_clean <= 1'b0;
    end else begin
      state        <= state_n;
      deb_cnt      <= deb_cnt_n;
      sensor_clean <= clean_n;
    end
  end

  // The sample that enters a CHECK state is the first of the run, so deb_cnt
  // holds the further differing samples; the run completes when the current
  // sample brings the total to DEB_CYCLES.
  assign deb_done = (int'(deb_cnt) + 2 >= DEB_CYCLES);

  // Debounce next-state logic.
  always_comb begin
    state_n   = state;
    deb_cnt_n = deb_cnt;
    case (state)
      LOW_STABLE: begin
        if (s2) begin
          state_n   = (DEB_CYCLES == 1) ? HIGH_STABLE : LOW_CHECK;
          deb_cnt_n = '0;
        end
      end
      LOW_CHECK: begin
        if (!s2) begin
          state_n   = LOW_STABLE;
          deb_cnt_n = '0;
        end else if (deb_done) begin
          state_n   = HIGH_STABLE;
          deb_cnt_n = '0;
        end else begin
          deb_cnt_n = deb_cnt + 1'b1;
        end
      end
      HIGH_STABLE: begin
        if (!s2) begin
          state_n   = (DEB_CYCLES == 1) ? LOW_STABLE : HIGH_CHECK;
          deb_cnt_n = '0;
        end
      end
      HIGH_CHECK: begin
        if (s2) begin
          state_n   = HIGH_STABLE;
          deb_cnt_n = '0;
        end else if (deb_done) begin
          state_n   = LOW_STABLE;
          deb_cnt_n = '0;
        end else begin
          deb_cnt_n = deb_cnt + 1'b1;
        end
      end
      default: begin
        state_n   = LOW_STABLE;
        deb_cnt_n = '0;
      end
    endcase
  end

  // Debounce outputs: next clean level and the single-cycle arrival event.
  always_comb begin
    clean_n = (state_n == HIGH_STABLE) || (state_n == HIGH_CHECK);
    arrival = clean_n && !sensor_clean;
  end

  // Departure timer only runs while cars wait under country green; any other
  // cycle discards a partial count.
  assign green_active = (cntry == GREEN) && (car_count != '0);
  assign departure    = green_active && (tmr == TW'(DEPART_CYCLES - 1));

  // Next timer value: reload on a departure, zero when not running.
  always_comb begin
    tmr_n = '0;
    if (green_active && !departure) tmr_n = tmr + 1'b1;
  end

  // Departure timer register.
  always_ff @(posedge clock) begin
    if (clear) tmr <= '0;
    else       tmr <= tmr_n;
  end

  assign at_max = (car_count == CNT_W'(MAX_CARS));

  // Waiting-car count and sticky overflow; coincident arrival and departure
  // cancel, so overflow marks only arrivals that are actually lost.
  always_ff @(posedge clock) begin
    if (clear) begin
      car_count <= '0;
      overflow  <= 1'b0;
    end else begin
      case ({arrival, departure})
        2'b10: begin
          if (at_max) overflow  <= 1'b1;
          else        car_count <= car_count + 1'b1;
        end
        2'b01:   car_count <= car_count - 1'b1;
        default: car_count <= car_count;
      endcase
    end
  end

  assign x = (car_count != '0);

endmodule
